rx_serial_7e1: RTL and testbench

- Serial receiver for the 7E1 frame format: 1 start bit, 7 data bits LSB first, even parity, 1 stop bit. Default rate is 115200 baud at a 50 MHz clock.
- It is the receive end of the link already driven by the 7E1 transmitter. It will carry host commands (e.g. pause/resume sweep) into the sonar control unit.
- It delivers each received character with a one-cycle completion pulse and a held "data available" flag, cleared by a consumer handshake.

---
 rtl/rx_serial_7e1_pkg.sv | 41 ++++
 rtl/rx_serial_7e1_if.sv | 22 ++
 rtl/rx_serial_7e1_tick.sv | 27 ++
 rtl/rx_serial_7e1.sv | 116 +++++++++++
 tb/tb_rx_serial_7e1.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/rx_serial_7e1_pkg.sv
// rtl/rx_serial_7e1_pkg.sv - shared constants, state codes and 7-segment encoder for the 7E1 receiver
package rx_serial_7e1_pkg;

    localparam int DATA_BITS    = 7;
    localparam bit PARITY_EVEN  = 1'b1;
    localparam int BAUD_DIV_DEF = 434;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        START  = 4'd1,
        DATA   = 4'd2,
        PARITY = 4'd3,
        STOP   = 4'd4,
        DONE   = 4'd5
    } state_t;

    // Active-low gfedcba pattern for a hex digit.
    function automatic logic [6:0] seg7_code(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return ~seg;
    endfunction

endpackage

// File: rtl/rx_serial_7e1_if.sv
// rtl/rx_serial_7e1_if.sv - serial line, consumer handshake and status bundle of the 7E1 receiver
interface rx_serial_7e1_if;
    logic       dado_serial;
    logic       recebe_dado;
    logic [6:0] dados_ascii;
    logic       pronto;
    logic       tem_dado;
    logic       erro_paridade;
    logic       erro_stop;
    logic       sobrescrita;
    logic [6:0] db_estado;

    modport master (
        output dado_serial, recebe_dado,
        input  dados_ascii, pronto, tem_dado, erro_paridade, erro_stop, sobrescrita, db_estado
    );

    modport slave (
        input  dado_serial, recebe_dado,
        output dados_ascii, pronto, tem_dado, erro_paridade, erro_stop, sobrescrita, db_estado
    );
endinterface

// File: rtl/rx_serial_7e1_tick.sv
// rtl/rx_serial_7e1_tick.sv - bit timer with mid-bit and end-of-bit strobes
module rx_tick_gen #(
    parameter int BAUD_DIV = 434,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    output logic o_meio_bit,
    output logic o_fim_bit
);
    localparam int CW = $clog2(BAUD_DIV);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clear)
            r_count <= '0;
        else if (r_count == CW'(BAUD_DIV - 1))
            r_count <= '0;
        else
            r_count <= r_count + 1'b1;
    end

    assign o_meio_bit = (r_count == CW'(HALF_DIV - 1));
    assign o_fim_bit  = (r_count == CW'(BAUD_DIV - 1));
endmodule

// File: rtl/rx_serial_7e1.sv
// rtl/rx_serial_7e1.sv - 7E1 serial receiver: synchronizer, frame FSM, result and handshake registers
module rx_serial_7e1
    import rx_serial_7e1_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic          clock,
    input  logic          reset,
    rx_serial_7e1_if.slave bus
);
    logic       r_sync1, r_sync2;
    state_t     r_state, w_next;
    logic [2:0] r_bit_idx;
    logic [6:0] r_shift;
    logic       r_par, r_stop;
    logic [6:0] r_dados;
    logic       r_tem, r_erro_par, r_erro_stop, r_sob;
    logic       w_s_rx, w_meio, w_fim, w_clear, w_pronto;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.dado_serial;
            r_sync2 <= r_sync1;
        end
    end
    assign w_s_rx = r_sync2;

    rx_tick_gen #(.BAUD_DIV(BAUD_DIV), .HALF_DIV(HALF_DIV)) u_tick (
        .clock      (clock),
        .reset      (reset),
        .i_clear    (w_clear),
        .o_meio_bit (w_meio),
        .o_fim_bit  (w_fim)
    );

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_s_rx) w_next = START;
            START:   if (w_meio) w_next = w_s_rx ? IDLE : DATA;
            DATA:    if (w_fim && r_bit_idx == 3'(DATA_BITS - 1)) w_next = PARITY;
            PARITY:  if (w_fim) w_next = STOP;
            STOP:    if (w_fim) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Timer is held at zero while idle and realigned to bit boundaries once the start bit is confirmed.
    always_comb begin
        w_clear  = (r_state == IDLE) || (r_state == START && w_meio && !w_s_rx);
        w_pronto = (r_state == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_par     <= 1'b0;
            r_stop    <= 1'b0;
        end else begin
            case (r_state)
                START:  if (w_meio) r_bit_idx <= '0;
                DATA:   if (w_fim) begin
                            r_shift   <= {w_s_rx, r_shift[6:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                PARITY: if (w_fim) r_par  <= w_s_rx;
                STOP:   if (w_fim) r_stop <= w_s_rx;
                default: ;
            endcase
        end
    end

    // A completing frame takes priority over a same-cycle acknowledge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dados     <= '0;
            r_tem       <= 1'b0;
            r_erro_par  <= 1'b0;
            r_erro_stop <= 1'b0;
            r_sob       <= 1'b0;
        end else if (r_state == DONE) begin
            r_dados     <= r_shift;
            r_erro_par  <= (^{r_shift, r_par}) ^ !PARITY_EVEN;
            r_erro_stop <= ~r_stop;
            r_tem       <= 1'b1;
            if (bus.recebe_dado)
                r_sob <= 1'b0;
            else if (r_tem)
                r_sob <= 1'b1;
        end else if (bus.recebe_dado) begin
            r_tem <= 1'b0;
            r_sob <= 1'b0;
        end
    end

    assign bus.dados_ascii   = r_dados;
    assign bus.pronto        = w_pronto;
    assign bus.tem_dado      = r_tem;
    assign bus.erro_paridade = r_erro_par;
    assign bus.erro_stop     = r_erro_stop;
    assign bus.sobrescrita   = r_sob;
    assign bus.db_estado     = seg7_code(r_state);
endmodule

// File: tb/tb_rx_serial_7e1.sv
// tb/tb_rx_serial_7e1.sv - randomized and directed bench for the 7E1 receiver against a frame-level model
module tb_rx_serial_7e1;
    localparam int BAUD     = 434;
    localparam int DONE_OFS = 2 + BAUD / 2 + 9 * BAUD + 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    rx_serial_7e1_if bus();

    rx_serial_7e1 #(.BAUD_DIV(BAUD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_pronto = 0;
    int last_pronto = -1;

    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [6:0] m_dados;
    logic       m_tem, m_sob, m_ep, m_es;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.pronto) begin
            n_pronto++;
            last_pronto = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("dados_ascii", 32'(bus.dados_ascii), 32'(m_dados));
        check("tem_dado", 32'(bus.tem_dado), 32'(m_tem));
        check("sobrescrita", 32'(bus.sobrescrita), 32'(m_sob));
        check("erro_paridade", 32'(bus.erro_paridade), 32'(m_ep));
        check("erro_stop", 32'(bus.erro_stop), 32'(m_es));
    endtask

    task automatic model_reset();
        m_dados = '0;
        m_tem   = 1'b0;
        m_sob   = 1'b0;
        m_ep    = 1'b0;
        m_es    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic ack();
        @(negedge clock);
        bus.recebe_dado = 1'b1;
        @(negedge clock);
        bus.recebe_dado = 1'b0;
        m_tem = 1'b0;
        m_sob = 1'b0;
        check("ack_tem_dado", 32'(bus.tem_dado), 32'(m_tem));
        check("ack_sobrescrita", 32'(bus.sobrescrita), 32'(m_sob));
    endtask

    // Drives one whole frame from a negedge; abort_at >= 0 applies reset at that line offset instead.
    task automatic send_frame(input logic [6:0] d, input bit par_err, input bit stop_bit,
                              input bit ack_done, input int abort_at);
        logic [9:0] bits;
        logic       p;
        int         t0, np0, ofs;
        p    = (($countones(d) % 2) == 1) ^ par_err;
        bits = {stop_bit, p, d, 1'b0};
        @(negedge clock);
        t0  = cyc;
        np0 = n_pronto;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < BAUD; k++) begin
                ofs = b * BAUD + k;
                if (ofs == abort_at) begin
                    reset = 1'b1;
                    @(negedge clock);
                    model_reset();
                    check_all();
                    check("abort_pronto", 32'(bus.pronto), 32'd0);
                    check("abort_db_estado", 32'(bus.db_estado), 32'(seg_ref[0]));
                    bus.dado_serial = 1'b1;
                    reset = 1'b0;
                    check("abort_no_pronto", 32'(n_pronto - np0), 32'd0);
                    return;
                end
                bus.dado_serial = bits[b];
                if (ack_done) bus.recebe_dado = (ofs == DONE_OFS);
                if (!stop_bit && ofs == DONE_OFS + 80)
                    check("break_restart", 32'(bus.db_estado), 32'(seg_ref[1]));
                @(negedge clock);
            end
        end
        bus.dado_serial = 1'b1;
        bus.recebe_dado = 1'b0;
        check("pronto_count", 32'(n_pronto - np0), 32'd1);
        check("pronto_cycle", 32'(last_pronto - t0), 32'(DONE_OFS));
        m_dados = d;
        m_ep    = ($countones({p, d}) % 2) == 1;
        m_es    = !stop_bit;
        m_sob   = ack_done ? 1'b0 : (m_sob | m_tem);
        m_tem   = 1'b1;
        check_all();
    endtask

    initial begin
        #(20 * 120000);
        $display("FAIL watchdog cycle=%0d expected finish", cyc);
        $fatal(1);
    end

    initial begin
        int np0;
        bus.dado_serial = 1'b1;
        bus.recebe_dado = 1'b0;
        reset = 1'b1;
        model_reset();
        idle(3);
        check_all();
        check("reset_pronto", 32'(bus.pronto), 32'd0);
        check("reset_db_estado", 32'(bus.db_estado), 32'(seg_ref[0]));
        reset = 1'b0;
        idle(10);

        send_frame(7'h41, 1'b0, 1'b1, 1'b0, -1);
        idle(50);
        send_frame(7'h43, 1'b1, 1'b1, 1'b0, -1);
        ack();
        idle(50);

        send_frame(7'h30, 1'b0, 1'b0, 1'b0, -1);
        idle(50);
        check("break_back_idle", 32'(bus.db_estado), 32'(seg_ref[0]));

        np0 = n_pronto;
        bus.dado_serial = 1'b0;
        idle(50);
        check("glitch_in_start", 32'(bus.db_estado), 32'(seg_ref[1]));
        idle(50);
        bus.dado_serial = 1'b1;
        idle(400);
        check("glitch_idle", 32'(bus.db_estado), 32'(seg_ref[0]));
        check("glitch_no_pronto", 32'(n_pronto - np0), 32'd0);
        check_all();

        ack();
        send_frame(7'h31, 1'b0, 1'b1, 1'b0, -1);
        idle(30);
        send_frame(7'h32, 1'b0, 1'b1, 1'b0, -1);
        ack();
        send_frame(7'h55, 1'b0, 1'b1, 1'b0, -1);
        idle(30);
        send_frame(7'h2A, 1'b0, 1'b1, 1'b1, -1);
        idle(30);

        send_frame(7'h41, 1'b0, 1'b1, 1'b0, 4 * BAUD + 164);
        idle(20);
        send_frame(7'h41, 1'b0, 1'b1, 1'b0, -1);
        idle(30);

        for (int i = 0; i < 6; i++) begin
            send_frame(7'($urandom), ($urandom % 4) == 0, ($urandom % 4) != 0, 1'b0, -1);
            if (($urandom % 2) == 1) ack();
            idle($urandom_range(20, 200));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
